// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin arbiter/sequencer sharing one single-port memory
//
// Purpose: grants one of NREQ requesters at a time, drives the memory
// valid/ready handshake for that access, returns read data or a completion
// pulse, and aborts accesses the memory never acknowledges (watchdog).
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i/wr_i         per-requester request and direction (1=write)
//   req_addr_i/wdata_i       flattened per-requester address / write data
//   done_o, err_o            one-hot completion pulse, timeout qualifier
//   rdata_o                  read data of the last completed read
//   busy_o                   access in flight (ISSUE or RESP)
//   mem_*_o / mem_*_i        memory-side handshake
module mem_access_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 4,
  parameter int DEPTH   = 16,
  parameter int AWIDTH  = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ-1:0]          req_wr_i,
  input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata_i,
  output logic [NREQ-1:0]          done_o,
  output logic                     err_o,
  output logic [DWIDTH-1:0]        rdata_o,
  output logic                     busy_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  output logic [DWIDTH-1:0]        mem_wdata_o,
  output logic                     mem_valid_o,
  output logic                     mem_wr_en_o,
  output logic                     mem_rd_en_o,
  input  logic [DWIDTH-1:0]        mem_rdata_i,
  input  logic                     mem_ready_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // With the watchdog disabled the counter is kept at one bit so it still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the edge that completes TIMEOUT cycles of waiting.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                err_q, err_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic                any_req;
  logic [IW-1:0]       pick;
  logic                timeout_hit;

  // Round-robin pick: first requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int  idx;
    logic found;
    any_req = |req_valid_i;
    pick    = rr_ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register (also holds the registered outputs and latched request).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: if (mem_ready_i || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; done_o and err_o default low so they pulse.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    mem_valid_d = mem_valid_q;
    mem_wr_en_d = mem_wr_en_q;
    mem_rd_en_d = mem_rd_en_q;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d       = pick;
          addr_d      = req_addr_i[int'(pick)*AWIDTH +: AWIDTH];
          wdata_d     = req_wdata_i[int'(pick)*DWIDTH +: DWIDTH];
          wr_d        = req_wr_i[pick];
          mem_valid_d = 1'b1;
          mem_wr_en_d = req_wr_i[pick];
          mem_rd_en_d = ~req_wr_i[pick];
          cnt_d       = '0;
          busy_d      = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // Ready wins over a timeout reached on the same edge.
        if (mem_ready_i || timeout_hit) begin
          mem_valid_d   = 1'b0;
          mem_wr_en_d   = 1'b0;
          mem_rd_en_d   = 1'b0;
          done_d[win_q] = 1'b1;
          err_d         = ~mem_ready_i;
          rr_ptr_d      = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          if (!mem_ready_i)   rdata_d = '0;
          else if (!wr_q)     rdata_d = mem_rdata_i;
        end
      end
      S_RESP: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign mem_rd_en_o = mem_rd_en_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard testbench for mem_access_arbiter
module tb_mem_access_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int AW   = 4;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_wr    = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    done_o;
  logic               err_o;
  logic [DW-1:0]      rdata_o;
  logic               busy_o;
  logic [AW-1:0]      mem_addr_o;
  logic [DW-1:0]      mem_wdata_o;
  logic               mem_valid_o;
  logic               mem_wr_en_o;
  logic               mem_rd_en_o;
  logic [DW-1:0]      mem_rdata = '0;
  logic               mem_ready = 1'b0;

  mem_access_arbiter #(
    .NREQ(NREQ), .DWIDTH(DW), .DEPTH(16), .AWIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_o(mem_valid_o), .mem_wr_en_o(mem_wr_en_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct packed {
    logic [NREQ-1:0] done;
    logic            err;
    logic            rd;
    logic [DW-1:0]   rdata;
  } exp_t;

  op_t  opq [NREQ][$];
  exp_t sbq [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic     flush    = 1'b0;
  logic     mem_dead = 1'b0;
  int       mem_lat  = 0;
  logic [DW-1:0] shadow [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: content starts as 15-addr; ready after mem_lat extra cycles.
  logic [DW-1:0] mem [16];
  logic mem_init = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 16; a++) mem[a] = DW'(15 - a);
      mem_init = 1'b1;
    end
    if (mem_valid_o && mem_dead) begin
      mem_ready = 1'b0;
      mem_rdata = 4'hF;
    end else if (mem_valid_o) begin
      wcnt = wcnt + 1;
      if (wcnt > mem_lat && !mem_ready) begin
        mem_ready = 1'b1;
        if (mem_wr_en_o) mem[mem_addr_o] = mem_wdata_o;
        else             mem_rdata = mem[mem_addr_o];
      end
    end else begin
      wcnt      = 0;
      mem_ready = 1'b0;
    end
  end

  // Requester driver: presents queued ops, retires one per done pulse.
  always @(negedge clk) begin
    if (flush) begin
      for (int k = 0; k < NREQ; k++) opq[k].delete();
      req_valid = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (done_o[k] && req_valid[k]) begin
          void'(opq[k].pop_front());
          req_valid[k] = 1'b0;
        end
        if (!req_valid[k] && opq[k].size() > 0) begin
          req_valid[k]             = 1'b1;
          req_wr[k]                = opq[k][0].wr;
          req_addr[k*AW +: AW]     = opq[k][0].addr;
          req_wdata[k*DW +: DW]    = opq[k][0].data;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  logic [DW-1:0] rdata_hold = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rdata_hold = '0;
    end else if (done_o != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        e = sbq.pop_front();
        if (e.rd || e.err) rdata_hold = e.rdata;
        chk("done", 32'(done_o), 32'(e.done));
        chk("err", 32'(err_o), 32'(e.err));
        chk("rdata", 32'(rdata_o), 32'(rdata_hold));
        chk("busy_resp", 32'(busy_o), 32'd1);
      end
    end
  end

  task automatic op(input int k, input logic wr, input int addr, input logic [DW-1:0] data);
    op_t o;
    o.wr = wr; o.addr = AW'(addr); o.data = data;
    opq[k].push_back(o);
  endtask

  task automatic expect_done(input int k, input logic err, input logic rd, input logic [DW-1:0] rdata);
    exp_t e;
    e.done = NREQ'(1) << k; e.err = err; e.rd = rd; e.rdata = rdata;
    sbq.push_back(e);
  endtask

  // Returns at the posedge where requester k's valid is first sampled.
  task automatic wait_req_edge(input int k);
    int i;
    i = 0;
    @(posedge clk);
    while (!req_valid[k] && i < 20) begin
      @(posedge clk);
      i++;
    end
    chk("req_wait_timeout", 32'(i >= 20), 32'd0);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    logic idle;
    i = 0;
    idle = 1'b0;
    while (!idle && i < budget) begin
      @(posedge clk);
      #2;
      i++;
      idle = (sbq.size() == 0) && !busy_o && (req_valid == '0);
      for (int k = 0; k < NREQ; k++) if (opq[k].size() != 0) idle = 1'b0;
    end
    chk("drain_timeout", 32'(!idle), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_mvalid"}, 32'(mem_valid_o), 32'd0);
    chk({tag, "_wren"}, 32'(mem_wr_en_o), 32'd0);
    chk({tag, "_rden"}, 32'(mem_rd_en_o), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr_o), 32'd0);
  endtask

  task automatic count_valid(output int n);
    n = 0;
    @(negedge clk);
    while (mem_valid_o && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int nv;
    logic [DW-1:0] d;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("por");
    rst_n = 1'b1;

    // Single write then read on requester 0.
    op(0, 1'b1, 3, 4'hA);
    expect_done(0, 1'b0, 1'b0, 4'h0);
    wait_req_edge(0);
    @(negedge clk);
    chk("wr_latency_valid", 32'(mem_valid_o), 32'd1);
    chk("wr_latency_wren", 32'(mem_wr_en_o), 32'd1);
    chk("wr_latency_rden", 32'(mem_rd_en_o), 32'd0);
    chk("wr_latency_addr", 32'(mem_addr_o), 32'h3);
    chk("wr_latency_wdata", 32'(mem_wdata_o), 32'hA);
    chk("wr_latency_busy", 32'(busy_o), 32'd1);
    wait_drain(100);
    op(0, 1'b0, 3, 4'h0);
    expect_done(0, 1'b0, 1'b1, 4'hA);
    wait_drain(100);

    // Round robin from reset: all four request, requester 0 twice.
    do_reset();
    op(0, 1'b0, 4, 4'h0); op(1, 1'b0, 5, 4'h0); op(2, 1'b0, 6, 4'h0);
    op(3, 1'b0, 7, 4'h0); op(0, 1'b0, 8, 4'h0);
    expect_done(0, 1'b0, 1'b1, 4'hB);
    expect_done(1, 1'b0, 1'b1, 4'hA);
    expect_done(2, 1'b0, 1'b1, 4'h9);
    expect_done(3, 1'b0, 1'b1, 4'h8);
    expect_done(0, 1'b0, 1'b1, 4'h7);
    wait_drain(200);

    // Timeout: memory never answers.
    mem_dead = 1'b1;
    op(2, 1'b0, 10, 4'h0);
    expect_done(2, 1'b1, 1'b1, 4'h0);
    wait_req_edge(2);
    count_valid(nv);
    chk("tmo_valid_cycles", 32'(nv), 32'd15);
    @(negedge clk);
    chk("tmo_busy_after", 32'(busy_o), 32'd0);
    wait_drain(100);
    mem_dead = 1'b0;
    // rr_ptr advanced past 2, so 3 is served before 2.
    op(2, 1'b0, 11, 4'h0); op(3, 1'b0, 12, 4'h0);
    expect_done(3, 1'b0, 1'b1, 4'h3);
    expect_done(2, 1'b0, 1'b1, 4'h4);
    wait_drain(100);

    // Ready arrives exactly on the timeout edge.
    mem_lat = 14;
    op(1, 1'b0, 9, 4'h0);
    expect_done(1, 1'b0, 1'b1, 4'h6);
    wait_req_edge(1);
    count_valid(nv);
    chk("edge_valid_cycles", 32'(nv), 32'd15);
    wait_drain(100);
    mem_lat = 0;

    // Reset in the middle of ISSUE: access abandoned, pointer back to 0.
    mem_dead = 1'b1;
    op(3, 1'b0, 1, 4'h0);
    wait_req_edge(3);
    @(negedge clk);
    chk("mid_valid", 32'(mem_valid_o), 32'd1);
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mem_dead = 1'b0;
    @(negedge clk);
    op(0, 1'b0, 13, 4'h0); op(2, 1'b0, 14, 4'h0);
    expect_done(0, 1'b0, 1'b1, 4'h2);
    expect_done(2, 1'b0, 1'b1, 4'h1);
    wait_drain(100);

    // Full sweep: requesters 1 and 2 interleave writes, then read back.
    mem_lat = 2;
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom);
      op(1, 1'b1, i, d);
      shadow[i] = d;
      expect_done(1, 1'b0, 1'b0, 4'h0);
      d = DW'($urandom);
      op(2, 1'b1, 15 - i, d);
      shadow[15 - i] = d;
      expect_done(2, 1'b0, 1'b0, 4'h0);
    end
    wait_drain(1000);
    for (int i = 0; i < 8; i++) begin
      op(1, 1'b0, i, 4'h0);
      expect_done(1, 1'b0, 1'b1, shadow[i]);
      op(2, 1'b0, 8 + i, 4'h0);
      expect_done(2, 1'b0, 1'b1, shadow[8 + i]);
    end
    wait_drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one single-port memory (memdes-style handshake: addr/wdata/valid/wr_en/rd_en in, rdata/ready out) between NREQ requesters.
- Accepts one request at a time, drives the memory handshake until ready, and returns read data or a completion pulse to the winner.
- Includes a watchdog that aborts accesses the memory never acknowledges.
- Sits between client blocks (DMA, CPU port, bench drivers) and the memory instance.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DWIDTH, 4, memory data width.
- DEPTH, 16, memory depth in words.
- AWIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 15, max ISSUE cycles awaiting mem_ready_i; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  NREQ  per-requester request; held until that requester's done pulse.
- req_wr_i  in  NREQ  1=write, 0=read, per requester.
- req_addr_i  in  NREQ*AWIDTH  flattened addresses; requester k uses bits [k*AWIDTH +: AWIDTH].
- req_wdata_i  in  NREQ*DWIDTH  flattened write data, same packing.
- done_o  out  NREQ  one-hot, one-cycle completion pulse.
- err_o  out  1  qualifies done_o; 1 means the access timed out.
- rdata_o  out  DWIDTH  read data, valid while done_o≠0 for a read; held until the next done.
- busy_o  out  1  high in ISSUE and RESP.
- mem_addr_o  out  AWIDTH  to memory addr_i.
- mem_wdata_o  out  DWIDTH  to memory wdata_i.
- mem_valid_o  out  1  to memory valid_i.
- mem_wr_en_o  out  1  to memory wr_en.
- mem_rd_en_o  out  1  to memory rd_en.
- mem_rdata_i  in  DWIDTH  from memory rdata_o.
- mem_ready_i  in  1  from memory ready_o.

Behaviour:
- Reset (rst_ni=0 sampled at posedge) clears:
  - all outputs to 0;
  - state=IDLE, rr_ptr=0, timeout counter=0, winner register=0.
  - Overrides any in-flight access, which is abandoned with no done pulse.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, when any req_valid_i bit is set at an edge:
  - Winner is the first set index scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - Latch the winner's index, addr, wdata and wr into registers.
  - Go to ISSUE, with outputs registered at that edge: mem_valid_o=1, mem_wr_en_o=wr, mem_rd_en_o=~wr, mem_addr_o/mem_wdata_o from the latched fields.
  - Latency: request sampled at edge N gives mem_valid_o high in the cycle after edge N.
- ISSUE:
  - All mem_* outputs stay stable; the counter increments each edge.
  - On an edge with mem_ready_i=1:
    - capture mem_rdata_i into rdata_o on reads only; writes leave rdata_o unchanged;
    - deassert mem_valid_o, mem_wr_en_o and mem_rd_en_o;
    - set done_o[winner]=1 and err_o=0;
    - set rr_ptr=(winner+1) mod NREQ;
    - go to RESP.
  - Timeout, when TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready_i still 0:
    - same exit path, but err_o=1 and rdata_o=0;
    - rr_ptr still advances.
  - mem_ready_i=1 on the same edge the timeout is reached: success takes priority (err_o=0).
- RESP:
  - done_o/err_o are high for exactly this one cycle.
  - Requests are ignored in RESP. The requester drops or changes req_valid_i on the edge that ends RESP.
  - Next state is IDLE.
  - Minimum spacing between back-to-back grants is 3 cycles plus memory wait.
- Fairness: a continuously requesting set is served strictly in rotation, so no requester waits more than NREQ-1 grants.
- Requests that deassert before grant are dropped silently. Changes to a granted requester's fields after latch are ignored.
- mem_ready_i seen in IDLE or RESP is ignored.
- Counter width is $clog2(TIMEOUT+1); it clears on entry to ISSUE.

Test Plan:
- Single write then read: req0 writes addr 0x3 data 0xA, then reads addr 0x3 → write: mem_wr_en_o=1 with addr 0x3 one cycle after request, done_o=4'b0001 one cycle after ready, err_o=0; read: done_o=4'b0001 again with rdata_o=0xA.
- Round-robin: all four requesters hold reads from reset → grant order 0,1,2,3,0; rr_ptr wraps 3→0; each done_o is one-hot; no requester is granted twice while another waits.
- Timeout: TIMEOUT=15, mem_ready_i tied 0 → mem_valid_o held 15 cycles, then done_o[winner]=1, err_o=1, rdata_o=0, busy_o=0 two edges later; rr_ptr advances.
- Ready on the timeout edge: mem_ready_i=1 exactly on count 15 → err_o=0 and rdata_o captured.
- Reset mid-ISSUE: rst_ni=0 for one edge while mem_valid_o=1 → all outputs 0 next cycle, no done pulse, next grant goes to requester 0.
- Full sweep: requesters 1 and 2 write all 16 addresses with $random data, interleaved, then read back → every read matches the last write to that address, and grants alternate 1,2.
